// File: rtl/pulse_scheduler_pkg.sv
// Shared types and defaults for the pulse scheduler.
// Holds the FSM state enum and default tick width / requester count.
package pulse_scheduler_pkg;

  localparam int N_DEF = 8;
  localparam int R_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot winner searching from ptr upward.
// Wraps from R-1 back to 0; no winner when req is all zero.
module rr_arbiter #(
  parameter int R  = 4,
  parameter int PW = 2
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  gnt
);

  int   j;
  logic found;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < R; k++) begin
      j = (int'(ptr) + k) % R;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared-timer pulse scheduler: grants one requester, times its delay.
// Optional abort input enabled by PULSE_SCHEDULER_ABORT_EN.
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [R-1:0] req,
  input  logic [R*N-1:0] req_ticks,
`ifdef PULSE_SCHEDULER_ABORT_EN
  input  logic         abort,
`endif
  output logic [R-1:0] grant,
  output logic [R-1:0] done,
  output logic         busy
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [R-1:0]  own_q, own_d;
  logic [R-1:0]  grant_q, grant_d;

  logic [R-1:0]  win;
  logic [N-1:0]  t_pick;
  logic [PW-1:0] ptr_nxt;
  logic          abort_i;

`ifdef PULSE_SCHEDULER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  rr_arbiter #(
    .R  (R),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (win)
  );

  // winner's delay and the pointer slot just past the winner
  always_comb begin
    t_pick  = '0;
    ptr_nxt = '0;
    for (int i = 0; i < R; i++) begin
      if (win[i]) begin
        t_pick  = t_pick | req_ticks[i*N +: N];
        ptr_nxt = (i == R - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // next-state, counter and grant logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = '0;
    unique case (state_q)
      IDLE: begin
        if (ena && (|req)) begin
          grant_d = win;
          own_d   = win;
          ptr_d   = ptr_nxt;
          cnt_d   = (t_pick == '0) ? N'(1) : t_pick;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (ena) begin
          if (cnt_q == N'(1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - N'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign done  = (state_q == DONE) ? own_q : '0;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Randomized and directed bench for pulse_scheduler.
// Reference model tracks owner/remaining ticks per cycle.
module tb_pulse_scheduler;

  localparam int N = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic [R-1:0] req = '0;
  logic [R*N-1:0] req_ticks = '0;
  logic         abort = 1'b0;
  logic [R-1:0] grant;
  logic [R-1:0] done;
  logic         busy;

  pulse_scheduler #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .req_ticks (req_ticks),
`ifdef PULSE_SCHEDULER_ABORT_EN
    .abort     (abort),
`endif
    .grant     (grant),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model
  int m_own  = -1;
  int m_rem  = 0;
  int m_nxt  = 0;
  bit m_done = 0;
  bit m_gnt  = 0;

  function automatic logic [R-1:0] oh(input int i);
    logic [R-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    m_own = -1; m_rem = 0; m_nxt = 0; m_done = 0; m_gnt = 0;
  endtask

  task automatic m_edge(input logic [R-1:0] rq,
                        input logic [R*N-1:0] tk,
                        input logic en, input logic ab);
    int w;
    if (m_done) begin
      m_own = -1; m_done = 0; m_gnt = 0;
    end else if (m_own >= 0) begin
      m_gnt = 0;
      if (ab) m_own = -1;
      else if (en) begin
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else begin
      m_gnt = 0;
      if (en && rq != 0) begin
        w = -1;
        for (int k = 0; k < R; k++)
          if (w < 0 && rq[(m_nxt + k) % R]) w = (m_nxt + k) % R;
        m_own = w;
        m_rem = int'(tk[w*N +: N]);
        if (m_rem == 0) m_rem = 1;
        m_gnt = 1;
        m_nxt = (w + 1) % R;
      end
    end
  endtask

  // observation log from the DUT
  int cyc = 0;
  int g_cyc = -1;
  int g_idx = -1;
  int d_cyc = -1;
  int busy_n = 0;
  int gq_idx[$];
  int gq_cyc[$];

  task automatic step(input logic [R-1:0] rq, input logic [R*N-1:0] tk,
                      input logic en, input logic rs, input logic ab);
    logic ab_m;
    @(negedge clk);
    chk("grant", grant, m_gnt ? oh(m_own) : '0);
    chk("done", done, m_done ? oh(m_own) : '0);
    chk("busy", busy, m_own >= 0);
    if (grant != 0) begin
      g_cyc = cyc;
      for (int i = 0; i < R; i++) if (grant[i]) g_idx = i;
      gq_idx.push_back(g_idx);
      gq_cyc.push_back(cyc);
    end
    if (done != 0) d_cyc = cyc;
    if (busy) busy_n++;
    cyc++;
`ifdef PULSE_SCHEDULER_ABORT_EN
    ab_m = ab;
`else
    ab_m = 1'b0;
`endif
    req = rq; req_ticks = tk; ena = en; rst = rs; abort = ab;
    if (!rs) begin
      m_reset();
      #1;
      chk("rst_out", {grant, done, busy}, '0);
    end else begin
      m_edge(rq, tk, en, ab_m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic clr();
    g_cyc = -1; d_cyc = -1; busy_n = 0;
    gq_idx.delete(); gq_cyc.delete();
  endtask

  task automatic do_rst();
    step('0, '0, 1'b1, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [R-1:0] rq;
    logic [R*N-1:0] tk;
    #1;
    chk("rst0", {grant, done, busy}, '0);
    do_rst();

    // single delay of 5
    clr();
    step(4'b0001, 32'd5, 1'b1, 1'b1, 1'b0);
    idle(9);
    chk("d5_idx", g_idx, 0);
    chk("d5_lat", d_cyc - g_cyc, 5);
    chk("d5_busy", busy_n, 6);

    // all requesting, ticks 2 each
    do_rst();
    clr();
    for (int i = 0; i < 18; i++)
      step(4'hF, {R{8'd2}}, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("rr_cnt", gq_idx.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gq_idx.size(); i++)
      chk($sformatf("rr_idx%0d", i), gq_idx[i], i % R);
    for (int i = 1; i < 5 && i < gq_cyc.size(); i++)
      chk($sformatf("rr_gap%0d", i), gq_cyc[i] - gq_cyc[i-1], 4);

    // ticks 0 and 255
    clr();
    step(4'b0010, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("t0_lat", d_cyc - g_cyc, 1);
    clr();
    step(4'b0100, 32'h00FF_0000, 1'b1, 1'b1, 1'b0);
    idle(258);
    chk("t255_lat", d_cyc - g_cyc, 255);

    // ena stalls 3 cycles mid-count
    clr();
    step(4'b1000, 32'h0400_0000, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("stall_lat", d_cyc - g_cyc, 7);

    // reset mid-count
    clr();
    step(4'b0100, 32'h0006_0000, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0, 1'b0);
    idle(8);
    chk("rst_nodone", d_cyc, -1);
    step(4'hF, {R{8'd1}}, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    chk("rst_next", g_idx, 0);
    idle(3);

`ifdef PULSE_SCHEDULER_ABORT_EN
    do_rst();
    clr();
    step(4'b0010, 32'h0000_0A00, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("ab_busy", busy, 1'b0);
    idle(12);
    chk("ab_nodone", d_cyc, -1);
    step(4'hF, {R{8'd1}}, 1'b1, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    chk("ab_next", g_idx, 2);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rq = R'($urandom);
      for (int k = 0; k < R; k++) tk[k*N +: N] = N'($urandom_range(0, 6));
      step(rq, tk, ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0));
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
